// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared state encoding and default sizes for the conv PE sequencer
package conv_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DRAIN
    } state_e;

    localparam int NUM_PE_D     = 16;
    localparam int MAC_CYCLES_D = 36;

endpackage

// File: rtl/conv_seq_window_cnt.sv
// rtl/conv_seq_window_cnt.sv - per-pixel MAC window counter with hold, first/last strobes
module conv_seq_window_cnt
    import conv_seq_pkg::*;
#(
    parameter int MAC_CYCLES = MAC_CYCLES_D
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic hold,
    output logic first,
    output logic last
);

    localparam int CW = $clog2(MAC_CYCLES);
    localparam logic [CW-1:0] W_LAST = CW'(MAC_CYCLES - 1);

    logic [CW-1:0] w_q, w_d;

    // Wrapping on last gives back-to-back windows with no idle gap.
    always_comb begin
        w_d = w_q;
        if (clear) begin
            w_d = '0;
        end else if (en && !hold) begin
            w_d = last ? '0 : w_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q <= '0;
        end else begin
            w_q <= w_d;
        end
    end

    assign first = (w_q == '0);
    assign last  = (w_q == W_LAST);

endmodule

// File: rtl/conv_pe_sequencer.sv
// rtl/conv_pe_sequencer.sv - PE_reset/PE_finish window sequencer for the 16-PE conv datapath
// Optional CONV_SEQ_PERF_EN adds saturating busy/hold cycle counters.
module conv_pe_sequencer
    import conv_seq_pkg::*;
#(
    parameter int NUM_PE      = NUM_PE_D,
    parameter int MAC_CYCLES  = MAC_CYCLES_D,
    parameter int START_DELAY = 3,
    parameter int PIX_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cal_start,
    input  logic              cal_abort,
    input  logic              hold,
    input  logic [PIX_W-1:0]  cfg_num_pixels,
    input  logic [NUM_PE-1:0] cfg_pe_mask,
    input  logic [NUM_PE-1:0] valid,
    output logic [NUM_PE-1:0] PE_reset,
    output logic [NUM_PE-1:0] PE_finish,
    output logic              busy,
    output logic              done,
    output logic [PIX_W-1:0]  pixel_idx,
    output logic              err_overflow
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_hold
`endif
);

    localparam int WAIT_W = $clog2(START_DELAY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_DELAY - 1);

    state_e            state_q;
    logic              cal_start_q;
    logic [PIX_W-1:0]  num_q, pixel_q, valid_cnt_q;
    logic [NUM_PE-1:0] mask_q;
    logic [WAIT_W-1:0] wait_q;
    logic              busy_q, err_q, done_zero_q;
    logic              win_first, win_last;
    logic              in_run, accept, issue_ok, fin, beat, ovf, done_drain;

    assign in_run     = (state_q == S_RUN);
    assign accept     = (state_q == S_IDLE) && cal_start && !cal_start_q;
    assign issue_ok   = in_run && !hold && !cal_abort;
    assign fin        = issue_ok && win_last;
    // Masked-off PEs never report, so they count as always valid.
    assign beat       = (in_run || state_q == S_DRAIN) && (&(valid | ~mask_q));
    // pixel_q doubles as the number of finishes already issued.
    assign ovf        = beat && (valid_cnt_q == pixel_q);
    assign done_drain = (state_q == S_DRAIN) && (valid_cnt_q == num_q) && !cal_abort;

    conv_seq_window_cnt #(
        .MAC_CYCLES(MAC_CYCLES)
    ) u_window_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(!in_run),
        .en   (in_run),
        .hold (hold),
        .first(win_first),
        .last (win_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cal_start_q <= 1'b0;
            num_q       <= '0;
            mask_q      <= '0;
            pixel_q     <= '0;
            valid_cnt_q <= '0;
            wait_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            done_zero_q <= 1'b0;
        end else begin
            cal_start_q <= cal_start;
            done_zero_q <= accept && (cfg_num_pixels == '0);
            if (ovf) begin
                err_q <= 1'b1;
            end else if (beat) begin
                valid_cnt_q <= valid_cnt_q + PIX_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        err_q <= 1'b0;
                        if (cfg_num_pixels != '0) begin
                            num_q       <= cfg_num_pixels;
                            mask_q      <= cfg_pe_mask;
                            pixel_q     <= '0;
                            valid_cnt_q <= '0;
                            wait_q      <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= S_RUN;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_RUN: begin
                    if (fin) begin
                        pixel_q <= pixel_q + PIX_W'(1);
                        if (pixel_q == num_q - PIX_W'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (done_drain) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (cal_abort && state_q != S_IDLE) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
            end
        end
    end

    assign PE_reset     = (issue_ok && win_first) ? mask_q : '0;
    assign PE_finish    = fin ? mask_q : '0;
    assign busy         = busy_q;
    assign done         = done_zero_q || done_drain;
    assign pixel_idx    = pixel_q;
    assign err_overflow = err_q;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_hold_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles_q <= '0;
            perf_hold_q   <= '0;
        end else if (accept) begin
            perf_cycles_q <= '0;
            perf_hold_q   <= '0;
        end else begin
            if (busy_q && !(&perf_cycles_q)) begin
                perf_cycles_q <= perf_cycles_q + 32'd1;
            end
            if (busy_q && hold && !(&perf_hold_q)) begin
                perf_hold_q <= perf_hold_q + 32'd1;
            end
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_hold   = perf_hold_q;
`endif

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// tb/tb_conv_pe_sequencer.sv - self-checking bench for conv_pe_sequencer
module tb_conv_pe_sequencer;

    localparam int MC = 36;
    localparam int SD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cal_start = 1'b0, cal_abort = 1'b0, hold = 1'b0;
    logic [15:0] num = '0, mask = '0, valid = '0;
    logic [15:0] pe_reset, pe_finish, pixel_idx;
    logic        busy, done, err_overflow;

    int cyc = 0;
    int n_pass = 0, n_total = 0;
    logic [15:0] spur = '0, echo_mask = '0;
    int due[$];
    int q_rst[$];
    int q_fin[$];
    int q_done[$];
    logic [15:0] last_rst_v = '0, last_fin_v = '0;
    int t_busy_obs = -1;
    int n_busy_cyc = 0;
    bit busy_prev = 1'b0;

    // Reference state: progress is tracked as a count of un-held RUN cycles.
    bit          m_busy, m_prev_start, m_dz, m_err;
    int          m_since, m_act, m_num, m_vcnt, m_pix_hold;
    logic [15:0] m_mask;

    conv_pe_sequencer dut (
        .clk           (clk),
        .reset         (rst_n),
        .cal_start     (cal_start),
        .cal_abort     (cal_abort),
        .hold          (hold),
        .cfg_num_pixels(num),
        .cfg_pe_mask   (mask),
        .valid         (valid),
        .PE_reset      (pe_reset),
        .PE_finish     (pe_finish),
        .busy          (busy),
        .done          (done),
        .pixel_idx     (pixel_idx),
        .err_overflow  (err_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Datapath stand-in: every finish is answered by a valid beat two cycles later.
    always begin
        @(posedge clk);
        #2;
        if (!rst_n) due.delete();
        valid = spur;
        if (due.size() > 0 && due[0] == cyc) begin
            valid = valid | echo_mask;
            void'(due.pop_front());
        end
    end

    always @(negedge clk) begin
        bit run, drain, beat, dn;
        int fin_cnt, pix;
        logic [15:0] e_rst, e_fin;
        if (!rst_n) begin
            m_busy = 0; m_prev_start = 0; m_dz = 0; m_err = 0;
            m_since = 0; m_act = 0; m_num = 0; m_vcnt = 0; m_pix_hold = 0; m_mask = '0;
            busy_prev = 0;
        end else begin
            if (|pe_reset) begin q_rst.push_back(cyc); last_rst_v = pe_reset; end
            if (|pe_finish) begin q_fin.push_back(cyc); last_fin_v = pe_finish; due.push_back(cyc + 2); end
            if (done) q_done.push_back(cyc);
            if (busy) n_busy_cyc++;
            if (busy && !busy_prev) t_busy_obs = cyc;
            busy_prev = busy;

            run     = m_busy && m_since >= SD && m_act < m_num * MC;
            drain   = m_busy && m_since >= SD && m_act == m_num * MC;
            fin_cnt = m_act / MC;
            pix     = m_busy ? fin_cnt : m_pix_hold;
            e_rst   = (run && !hold && !cal_abort && m_act % MC == 0) ? m_mask : 16'h0;
            e_fin   = (run && !hold && !cal_abort && m_act % MC == MC - 1) ? m_mask : 16'h0;
            beat    = (run || drain) && ((valid | ~m_mask) == 16'hFFFF);
            dn      = drain && m_vcnt == m_num && !cal_abort;

            chk("pe_reset", pe_reset, e_rst);
            chk("pe_finish", pe_finish, e_fin);
            chk("busy", busy, m_busy);
            chk("done", done, m_dz || dn);
            chk("pixel_idx", pixel_idx, pix);
            chk("err_overflow", err_overflow, m_err);

            m_dz = 0;
            if (beat) begin
                if (m_vcnt == fin_cnt) m_err = 1;
                else m_vcnt++;
            end
            if (m_busy) begin
                if (cal_abort) begin
                    m_busy = 0; m_pix_hold = fin_cnt;
                end else if (dn) begin
                    m_busy = 0; m_pix_hold = m_num;
                end else begin
                    if (run && !hold) m_act++;
                    m_since++;
                end
            end else if (cal_start && !m_prev_start) begin
                m_err = 0;
                if (num == 0) m_dz = 1;
                else begin
                    m_busy = 1; m_since = 0; m_act = 0; m_vcnt = 0;
                    m_num = int'(num); m_mask = mask;
                end
            end
            m_prev_start = cal_start;
        end
    end

    task automatic start_run(input int n, input logic [15:0] m, output int tb);
        int t0;
        q_rst.delete(); q_fin.delete(); q_done.delete();
        n_busy_cyc = 0; t_busy_obs = -1;
        num = 16'(n); mask = m; echo_mask = m;
        cal_start = 1'b1;
        t0 = cyc;
        step();
        cal_start = 1'b0;
        tb = t0 + 1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && q_done.size() == 0; i++) step();
        chk("done_seen", q_done.size(), 1);
    endtask

    initial begin
        int tb;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pe_reset", pe_reset, 0);
        chk("rst_pe_finish", pe_finish, 0);
        chk("rst_pixel_idx", pixel_idx, 0);
        chk("rst_err", err_overflow, 0);
        rst_n = 1'b1;
        repeat (2) step();

        // Nominal: 4 pixels, full mask
        start_run(4, 16'hFFFF, tb);
        wait_done(400);
        chk("nom_busy_rise", t_busy_obs, tb);
        chk("nom_n_reset", q_rst.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("nom_reset_t", qat(q_rst, i) - tb, 3 + MC * i);
            chk("nom_finish_t", qat(q_fin, i) - tb, 38 + MC * i);
        end
        chk("nom_done_t", qat(q_done, 0) - tb, 149);
        repeat (3) step();
        chk("nom_idle", busy, 0);

        // Hold for 5 cycles at w=10 of pixel 1
        start_run(2, 16'hFFFF, tb);
        wait_cyc(tb + 49);
        hold = 1'b1;
        repeat (5) step();
        hold = 1'b0;
        wait_done(300);
        chk("hold_fin0_t", qat(q_fin, 0) - tb, 38);
        chk("hold_rst1_t", qat(q_rst, 1) - tb, 39);
        chk("hold_fin1_t", qat(q_fin, 1) - tb, 79);
        chk("hold_done_t", qat(q_done, 0) - tb, 82);
        repeat (3) step();

        // Partial mask
        start_run(2, 16'h00FF, tb);
        wait_done(300);
        chk("mask_reset_v", last_rst_v, 16'h00FF);
        chk("mask_finish_v", last_fin_v, 16'h00FF);
        chk("mask_done_t", qat(q_done, 0) - tb, 77);
        repeat (3) step();

        // Abort at pixel 2, w=20, then restart
        start_run(4, 16'hFFFF, tb);
        wait_cyc(tb + 95);
        cal_abort = 1'b1;
        step();
        cal_abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_pe_reset", pe_reset, 0);
        chk("abort_pe_finish", pe_finish, 0);
        chk("abort_pixel_idx", pixel_idx, 2);
        repeat (10) step();
        chk("abort_no_done", q_done.size(), 0);
        chk("abort_n_reset", q_rst.size(), 3);
        start_run(2, 16'hFFFF, tb);
        wait_cyc(tb + 3);
        chk("restart_pe_reset", pe_reset, 16'hFFFF);
        chk("restart_pixel_idx", pixel_idx, 0);
        wait_done(300);
        repeat (3) step();

        // Zero pixels: lone done pulse
        start_run(0, 16'hFFFF, tb);
        repeat (4) step();
        chk("zero_n_done", q_done.size(), 1);
        chk("zero_done_t", qat(q_done, 0), tb);
        chk("zero_n_reset", q_rst.size(), 0);
        chk("zero_busy_cycles", n_busy_cyc, 0);

        // Overflow: spurious beat before any finish, then on the done cycle
        start_run(1, 16'hFFFF, tb);
        wait_cyc(tb + 10);
        spur = 16'hFFFF;
        step();
        spur = 16'h0;
        chk("ovf_run_err", err_overflow, 1);
        wait_done(200);
        chk("ovf_done_t", qat(q_done, 0) - tb, 41);
        repeat (2) step();
        start_run(1, 16'hFFFF, tb);
        chk("ovf_cleared", err_overflow, 0);
        wait_cyc(tb + 41);
        spur = 16'hFFFF;
        step();
        spur = 16'h0;
        chk("ovf_drain_err", err_overflow, 1);
        chk("ovf2_done_t", qat(q_done, 0) - tb, 41);
        repeat (3) step();

        // Reset mid-RUN on pixel 3's reset pulse
        start_run(4, 16'hFFFF, tb);
        wait_cyc(tb + 111);
        chk("mid_pe_reset_pre", pe_reset, 16'hFFFF);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_pe_reset", pe_reset, 0);
        chk("mid_pixel_idx", pixel_idx, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("mid_idle_busy", busy, 0);
        chk("mid_no_done", q_done.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_pe_sequencer.md
Name: conv_pe_sequencer

Overview:
- Generates the per-pixel PE control sequence (PE_reset / PE_finish) for the 16-PE conv datapath (Sub_top_2_CONV class) once IFM and weights are loaded, replacing hand-timed bench stimulus.
- Takes cal_start, issues one reset→MAC→finish window per OFM pixel back-to-back, counts returned valid beats and signals done.
- Sits between the top-level layer controller and the conv datapath.

Parameters:
- NUM_PE, 16, number of PEs / width of PE control vectors
- MAC_CYCLES, 36, cycles per OFM pixel window = K_H*K_W*IFM_C/4 (3*3*16/4); minimum 3
- START_DELAY, 3, cycles from accepted cal_start to first PE_reset; minimum 1
- PIX_W, 16, width of pixel counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- cal_start  in  1  start request; rising edge accepted only in IDLE
- cal_abort  in  1  synchronous abort; back to IDLE, no done
- hold  in  1  freeze window counter and PE outputs (upstream data not ready)
- cfg_num_pixels  in  PIX_W  OFM pixels to compute (3136 for 56x56); sampled on start
- cfg_pe_mask  in  NUM_PE  enabled PEs; sampled on start
- valid  in  NUM_PE  per-PE OFM valid from datapath
- PE_reset  out  NUM_PE  accumulator clear, one cycle per window
- PE_finish  out  NUM_PE  window end, one cycle per window
- busy  out  1  high from accepted start until done/abort
- done  out  1  one-cycle pulse after last valid collected
- pixel_idx  out  PIX_W  index of window currently issued
- err_overflow  out  1  sticky: valid beat with no outstanding window

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-run discards everything; no done.
- Async-assert / sync-deassert handled at top; block uses reset directly in all always_ff sensitivity lists.
- States: IDLE → WAIT (START_DELAY cycles) → RUN → DRAIN → IDLE.
- IDLE: on cal_start 0→1 with cfg_num_pixels≠0, latch cfg, busy=1, go WAIT. cfg_num_pixels=0: single-cycle done pulse, stay IDLE, busy stays 0.
- WAIT: count START_DELAY cycles, enter RUN with window counter w=0.
- RUN: w cycles 0..MAC_CYCLES-1. PE_reset=cfg_pe_mask at w=0; PE_finish=cfg_pe_mask at w=MAC_CYCLES-1; 0 otherwise. After finish, pixel_idx++, next cycle is w=0 of next pixel (no gap). After finish of pixel cfg_num_pixels-1 go DRAIN.
- hold=1: w, pixel_idx frozen, PE_reset/PE_finish forced 0 that cycle; pending pulse re-issued when hold drops.
- Valid beat = &(valid | ~cfg_pe_mask) in RUN or DRAIN; increments valid_cnt. Beat when valid_cnt == issued finishes sets err_overflow (cleared only by reset or new start).
- DRAIN: when valid_cnt == cfg_num_pixels, done=1 for one cycle, busy=0, IDLE same edge.
- cal_abort (any non-IDLE state): next cycle IDLE, busy=0, PE outputs 0, no done. Abort wins over simultaneous finish/done.
- cal_start while busy ignored. Counters are PIX_W wide; cfg_num_pixels ≤ 2^PIX_W-1, no wrap.

Optional Feature:
- CONV_SEQ_PERF_EN defined: adds outputs perf_cycles (32 b, cycles busy) and perf_hold (32 b, cycles with hold=1 while busy), cleared on accepted start, saturating at all-ones. Undefined: ports absent, no counter logic.

Decomposition:
- Package conv_seq_pkg: state enum (S_IDLE, S_WAIT, S_RUN, S_DRAIN), default constants NUM_PE_D=16, MAC_CYCLES_D=36.
- One sub-module natural: conv_seq_window_cnt (w counter with hold, emits first/last strobes). Rest flat.

Test Plan:
- Nominal: cfg_num_pixels=4, mask=FFFF, MAC_CYCLES=36, START_DELAY=3, valid echoed 2 cycles after finish → PE_reset at start+3, +39, +75, +111; four PE_finish 35 cycles after each reset; done one cycle after 4th valid.
- Hold: hold=1 for 5 cycles at w=10 of pixel 1 → pixel 1 finish delayed exactly 5 cycles, no pulses during hold.
- Mask: cfg_pe_mask=00FF, valid=00FF only → PE_reset/PE_finish=00FF, done still reached.
- Abort: cal_abort at pixel 2, w=20 → busy=0 next cycle, no done, PE outputs 0; new cal_start restarts at pixel_idx=0.
- Edge cases: cfg_num_pixels=0 → single done pulse, no PE_reset; spurious valid in DRAIN after completion count → err_overflow=1.
- Reset mid-RUN (reset=0 at pixel 3) → all outputs 0 immediately, IDLE after release.
